// File: rtl/am_similarity_accumulator_if.sv
// Beat handshake and result bus of the associative-memory similarity accumulator.
// master = query/class source, slave = accumulator.
interface am_similarity_accumulator_if #(
  parameter int unsigned NUM_CLASSES = 26,
  parameter int unsigned CHUNK_W     = 40,
  parameter int unsigned SIM_W       = 13
);
  logic               start;
  logic               in_valid;
  logic               in_ready;
  logic [CHUNK_W-1:0] query_chunk;
  logic [CHUNK_W-1:0] class_chunk;
  logic               busy;
  logic               inferring_class;
  logic [SIM_W-1:0]   similarity_values [0:NUM_CLASSES-1];

  modport master (
    output start, in_valid, query_chunk, class_chunk,
    input  in_ready, busy, inferring_class, similarity_values
  );

  modport slave (
    input  start, in_valid, query_chunk, class_chunk,
    output in_ready, busy, inferring_class, similarity_values
  );
endinterface

// File: rtl/am_similarity_accumulator.sv
// Scores a query hypervector against NUM_CLASSES class hypervectors by accumulating
// per-class Hamming agreement counts over chunk-major beats.
module am_similarity_accumulator #(
  parameter int unsigned NUM_CLASSES = 26,
  parameter int unsigned CHUNK_W     = 40,
  parameter int unsigned NUM_CHUNKS  = 125,
  parameter int unsigned SIM_W       = 13
) (
  input logic                     clk,
  input logic                     nrst,
  am_similarity_accumulator_if.slave bus
);
  localparam int unsigned PopW   = $clog2(CHUNK_W + 1);
  localparam int unsigned ClassW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int unsigned ChunkW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e            state_q, state_d;
  logic [ClassW-1:0] class_cnt_q, class_cnt_d;
  logic [ChunkW-1:0] chunk_cnt_q, chunk_cnt_d;
  logic [SIM_W-1:0]  acc_q [NUM_CLASSES];

  logic [CHUNK_W-1:0] agree;
  logic [PopW-1:0]    match_cnt;
  logic               xfer;
  logic               clear;
  logic               last_class;
  logic               last_chunk;

  assign agree      = ~(bus.query_chunk ^ bus.class_chunk);
  assign xfer       = (state_q == StAccum) && bus.in_valid;
  assign clear      = (state_q == StIdle) && bus.start;
  assign last_class = (class_cnt_q == ClassW'(NUM_CLASSES - 1));
  assign last_chunk = (chunk_cnt_q == ChunkW'(NUM_CHUNKS - 1));

  always_comb begin
    match_cnt = '0;
    for (int i = 0; i < int'(CHUNK_W); i++) begin
      match_cnt = match_cnt + PopW'(agree[i]);
    end
  end

  always_comb begin
    state_d     = state_q;
    class_cnt_d = class_cnt_q;
    chunk_cnt_d = chunk_cnt_q;
    unique case (state_q)
      StIdle: begin
        // start wins over a simultaneous in_valid; that beat is not consumed
        if (bus.start) begin
          state_d     = StAccum;
          class_cnt_d = '0;
          chunk_cnt_d = '0;
        end
      end
      StAccum: begin
        if (bus.in_valid) begin
          if (last_class) begin
            class_cnt_d = '0;
            if (last_chunk) begin
              chunk_cnt_d = '0;
              state_d     = StDone;
            end else begin
              chunk_cnt_d = chunk_cnt_q + 1'b1;
            end
          end else begin
            class_cnt_d = class_cnt_q + 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= StIdle;
      class_cnt_q <= '0;
      chunk_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      class_cnt_q <= class_cnt_d;
      chunk_cnt_q <= chunk_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int k = 0; k < int'(NUM_CLASSES); k++) acc_q[k] <= '0;
    end else if (clear) begin
      for (int k = 0; k < int'(NUM_CLASSES); k++) acc_q[k] <= '0;
    end else if (xfer) begin
      acc_q[class_cnt_q] <= acc_q[class_cnt_q] + SIM_W'(match_cnt);
    end
  end

  // Outputs decode from state only, so in_ready has no path from in_valid
  assign bus.in_ready        = (state_q == StAccum);
  assign bus.busy            = (state_q != StIdle);
  assign bus.inferring_class = (state_q == StDone);

  for (genvar k = 0; k < int'(NUM_CLASSES); k++) begin : g_out
    assign bus.similarity_values[k] = acc_q[k];
  end
endmodule

// File: tb/tb_am_similarity_accumulator.sv
// Randomized scoreboard bench for am_similarity_accumulator: the driver pushes the
// model's per-class scores and strobe time, a monitor pops them on each strobe.
module tb_am_similarity_accumulator;
  localparam int NC = 26;
  localparam int CW = 40;
  localparam int NCH = 125;
  localparam int SW = 13;
  localparam int NBEATS = NC * NCH;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;

  int unsigned exp_q[$];
  logic [CW-1:0] qv [NCH];
  logic [CW-1:0] cv [NC][NCH];
  int unsigned   model [NC];

  am_similarity_accumulator_if #(.NUM_CLASSES(NC), .CHUNK_W(CW), .SIM_W(SW)) bus ();

  am_similarity_accumulator #(
    .NUM_CLASSES(NC),
    .CHUNK_W    (CW),
    .NUM_CHUNKS (NCH),
    .SIM_W      (SW)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [CW-1:0] rnd();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    return w[CW-1:0];
  endfunction

  // Monitor: every strobe must match the oldest expected query
  always @(negedge clk) begin
    if (bus.inferring_class) begin
      if (exp_q.size() < NC + 1) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        for (int k = 0; k < NC; k++) begin
          chk($sformatf("sim[%0d]", k), 32'(bus.similarity_values[k]), exp_q.pop_front());
        end
        chk("strobe_cycle", cyc, exp_q.pop_front());
      end
    end
  end

  // mode 0: random, 1: class 7 equals query and others ~query, 2: zero query, k ones per slice
  task automatic gen_stim(input int mode);
    logic [CW-1:0] m;
    int r;
    for (int c = 0; c < NCH; c++) qv[c] = (mode == 2) ? '0 : rnd();
    for (int k = 0; k < NC; k++) begin
      for (int c = 0; c < NCH; c++) begin
        case (mode)
          1: cv[k][c] = (k == 7) ? qv[c] : ~qv[c];
          2: begin
            m = '0;
            for (int i = 0; i < k; i++) m[i] = 1'b1;
            r = $urandom_range(CW - 1);
            cv[k][c] = (m << r) | (m >> (CW - r));
          end
          default: cv[k][c] = rnd();
        endcase
      end
    end
    for (int k = 0; k < NC; k++) begin
      model[k] = 0;
      for (int c = 0; c < NCH; c++) model[k] += CW - $countones(qv[c] ^ cv[k][c]);
    end
  endtask

  task automatic check_held(input string name);
    for (int k = 0; k < NC; k++) chk(name, 32'(bus.similarity_values[k]), model[k]);
  endtask

  // Called and returns at a negedge; start is issued in the calling cycle
  task automatic run_query(input int mode, input int stall_pct, input bit proto,
                           input int abort_at, input int post_idle);
    int  n;
    int  stuck;
    bit  stall;
    logic [31:0] any;
    gen_stim(mode);
    if (proto) begin
      repeat (4) begin
        bus.in_valid = 1'b1;
        bus.query_chunk = rnd();
        bus.class_chunk = rnd();
        chk("idle_in_ready", 32'(bus.in_ready), 0);
        @(negedge clk);
      end
    end
    bus.start = 1'b1;
    bus.in_valid = proto;
    bus.query_chunk = rnd();
    bus.class_chunk = rnd();
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    stuck = 0;
    while (n < NBEATS) begin
      if (n == abort_at) begin
        nrst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_strobe", 32'(bus.inferring_class), 0);
        any = 0;
        for (int k = 0; k < NC; k++) any |= 32'(bus.similarity_values[k]);
        chk("rst_values", any, 0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (20) begin
          bus.in_valid = 1'b1;
          bus.query_chunk = rnd();
          bus.class_chunk = rnd();
          @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("post_rst_busy", 32'(bus.busy), 0);
        return;
      end
      stall = ($urandom_range(99) < stall_pct);
      bus.start = proto && (n == 500);
      bus.in_valid = !stall;
      bus.query_chunk = stall ? rnd() : qv[n / NC];
      bus.class_chunk = stall ? rnd() : cv[n % NC][n / NC];
      if (!stall) begin
        if (bus.in_ready) begin
          if (n == NBEATS - 1) begin
            for (int k = 0; k < NC; k++) exp_q.push_back(model[k]);
            exp_q.push_back(cyc + 1);
          end
          n++;
          stuck = 0;
        end else if (++stuck > 20) begin
          total++;
          bad++;
          $display("FAIL in_ready_timeout actual=0 required=1 (beat %0d)", n);
          bus.in_valid = 1'b0;
          return;
        end
      end
      @(negedge clk);
    end
    // DONE cycle: a beat offered here must be ignored
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    bus.query_chunk = rnd();
    bus.class_chunk = rnd();
    chk("done_busy", 32'(bus.busy), 1);
    chk("done_in_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_strobe", 32'(bus.inferring_class), 0);
    check_held("held_after_done");
    repeat (post_idle) begin
      bus.in_valid = 1'b1;
      bus.query_chunk = rnd();
      bus.class_chunk = rnd();
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (post_idle > 0) check_held("held_in_idle");
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.query_chunk = '0;
    bus.class_chunk = '0;
    #1;
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_in_ready", 32'(bus.in_ready), 0);
    chk("reset_strobe", 32'(bus.inferring_class), 0);
    chk("reset_sim0", 32'(bus.similarity_values[0]), 0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    run_query(1, 0, 1'b0, -1, 2);
    chk("match_sim7", 32'(bus.similarity_values[7]), 5000);
    chk("match_sim0", 32'(bus.similarity_values[0]), 0);

    run_query(2, 30, 1'b0, -1, 2);
    chk("fixed_sim0", 32'(bus.similarity_values[0]), 5000);
    chk("fixed_sim25", 32'(bus.similarity_values[25]), 1875);
    chk("fixed_sim13", 32'(bus.similarity_values[13]), 27 * 125);

    run_query(0, 40, 1'b0, -1, 0);
    run_query(0, 0, 1'b1, -1, 1);
    run_query(0, 10, 1'b0, 1000, 0);
    run_query(0, 0, 1'b0, -1, 0);
    run_query(0, 20, 1'b0, -1, 3);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/am_similarity_accumulator.md
AM_SIMILARITY_ACCUMULATOR -- requirements
Module: am_similarity_accumulator

Interface
REQ-001 The block SHALL have the parameter NUM_CLASSES, default 26, meaning the number of class hypervectors scored.
REQ-002 The block SHALL have the parameter CHUNK_W, default 40, meaning the hypervector bits per beat.
REQ-003 The block SHALL have the parameter NUM_CHUNKS, default 125, meaning the beats per class (CHUNK_W*NUM_CHUNKS = 5000 dims).
REQ-004 The block SHALL have the parameter SIM_W, default 13, meaning the similarity value width.
REQ-005 The block SHALL have the port clk, input, 1 bit, the single clock, rising-edge.
REQ-006 The block SHALL have the port nrst, input, 1 bit, the asynchronous active-low reset.
REQ-007 The block SHALL have the port start, input, 1 bit, a pulse that begins a new query.
REQ-008 The block SHALL have the port in_valid, input, 1 bit, meaning the beat data is valid.
REQ-009 The block SHALL have the port in_ready, output, 1 bit, meaning the block accepts a beat.
REQ-010 The block SHALL have the port query_chunk, input, CHUNK_W bits, the query hypervector slice.
REQ-011 The block SHALL have the port class_chunk, input, CHUNK_W bits, the class hypervector slice.
REQ-012 The block SHALL have the port busy, output, 1 bit, high while a query is in progress.
REQ-013 The block SHALL have the port inferring_class, output, 1 bit, a one-cycle strobe meaning the similarity values are final.
REQ-014 The block SHALL have the port similarity_values, output, array [0:NUM_CLASSES-1] of SIM_W bits, the per-class match counts.

Function
REQ-015 The FSM SHALL have the states IDLE, ACCUM and DONE, and SHALL enter IDLE on reset.
REQ-016 In IDLE, start=1 SHALL zero every accumulator, zero both counters and enter ACCUM on the next edge.
REQ-017 A beat SHALL transfer only on a rising edge with in_valid=1 and in_ready=1.
REQ-018 in_ready SHALL be 1 exactly in ACCUM, with no combinational path from in_valid.
REQ-019 The beat order SHALL be chunk-major: for chunk c = 0..NUM_CHUNKS-1, classes k = 0..NUM_CLASSES-1, with query_chunk carrying query slice c on every beat of chunk c.
REQ-020 The internal counters class_cnt (0..NUM_CLASSES-1) and chunk_cnt (0..NUM_CHUNKS-1) SHALL advance only on transfer; class_cnt SHALL wrap to 0 and increment chunk_cnt.
REQ-021 On a transfer, acc[class_cnt] SHALL become acc[class_cnt] plus popcount(~(query_chunk ^ class_chunk)), in the same edge.
REQ-022 The popcount width SHALL be clog2(CHUNK_W+1); the sum SHALL be SIM_W bits and SHALL NOT overflow for the defaults (max 5000 < 8192).
REQ-023 A transfer with class_cnt=NUM_CLASSES-1 and chunk_cnt=NUM_CHUNKS-1 SHALL move the FSM to DONE.
REQ-024 DONE SHALL last exactly one cycle with inferring_class=1, then return to IDLE, giving a latency of 1 cycle from the last beat edge to the strobe.
REQ-025 busy SHALL be 1 in ACCUM and DONE and 0 in IDLE.
REQ-026 similarity_values SHALL be driven directly from the accumulators, and SHALL hold the final values from DONE until the next accepted start.
REQ-027 start in ACCUM or DONE SHALL be ignored, with no effect on the counters or the accumulators.
REQ-028 in_valid in IDLE or DONE SHALL be ignored, and no accumulation SHALL occur.
REQ-029 If start and in_valid are both high in IDLE, only start SHALL take effect, and that beat SHALL NOT be consumed.
REQ-030 A gap in in_valid (a stall) SHALL freeze the counters and the accumulators without limit.

Reset
REQ-031 When nrst=0, the block SHALL asynchronously set the state to IDLE, the counters to 0, every accumulator to 0, in_ready=0, busy=0 and inferring_class=0.
REQ-032 A reset asserted during ACCUM SHALL abort the query, and no inferring_class strobe SHALL follow the release.
REQ-033 After reset is released, the first action SHALL require a new start.

Verification
REQ-034 Match test: class 7 beats equal the query and all other classes equal ~query -> similarity_values[7]=5000, all others 0, one inferring_class pulse.
REQ-035 Fixed-pattern test: query all-zero and class k's slices have exactly k ones per beat -> similarity_values[k] = (40-k)*125, i.e. [0]=5000 and [25]=1875.
REQ-036 Stall test: random in_valid gaps over the 3250 beats -> the results are identical to the no-stall run, and the strobe arrives 1 cycle after the 3250th transfer.
REQ-037 Protocol test: start pulsed mid-ACCUM and in_valid pulsed in IDLE -> the counters and accumulators are unchanged.
REQ-038 Reset test: nrst asserted at beat 1000 -> all outputs are 0 immediately; with no start there is no strobe; a fresh start followed by a full run gives correct values.
REQ-039 Back-to-back test: a second start one cycle after DONE -> the accumulators clear, and the second query's results are independent of the first.
